// File: rtl/seq_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | seq_ctrl_pkg : shared types and defaults for pattern_scan_controller |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    localparam int DEF_WORD_W    = 16;
    localparam int DEF_DRAIN_CYC = 1;

endpackage

`default_nettype wire

// File: rtl/word_serializer.sv
// +----------------------------------------------------------------------+
// | word_serializer : parallel-load, LSB-first shift register            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module word_serializer #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] d,
    output logic              q,
    output logic              last
);

    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bit_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
        end else if (load) begin
            r_shreg   <= d;
            r_bit_idx <= '0;
        end else if (shift) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_idx <= r_bit_idx + CNT_W'(1);
        end
    end

    assign q    = r_shreg[0];
    assign last = (r_bit_idx == CNT_W'(WORD_W - 1));

endmodule

`default_nettype wire

// File: rtl/pattern_scan_controller.sv
// +----------------------------------------------------------------------+
// | pattern_scan_controller : streams a word into a serial detector and  |
// | counts its hits. Option macro FIRST_HIT_POS_EN adds out_first_pos.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pattern_scan_controller
    import seq_ctrl_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CNT_W     = $clog2(WORD_W + 1),
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              abort,
    output logic              det_clear,
    output logic              det_bit_valid,
    output logic              det_data,
    input  logic              det_hit,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FIRST_HIT_POS_EN
    output logic [CNT_W-1:0]  out_first_pos,
`endif
    output logic [CNT_W-1:0]  out_count
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    logic             w_accept;
    logic             w_abort;
    logic             w_done_entry;
    logic             w_ser_q;
    logic             w_ser_last;
    logic             r_win;
    logic             r_det_clear;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] w_hit_cnt_nxt;
    logic [CNT_W-1:0] r_out_count;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_abort  = abort && ((r_state == CLEAR) || (r_state == SHIFT) || (r_state == DRAIN));

    word_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_ser (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_accept),
        .shift   (r_state == SHIFT),
        .d       (in_word),
        .q       (w_ser_q),
        .last    (w_ser_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = SHIFT;
            SHIFT:   if (w_ser_last) w_state_nxt = DRAIN;
            DRAIN:   if (r_drain_cnt == DRN_W'(DRAIN_CYC - 1)) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Cancel takes priority, including over DRAIN->DONE.
        if (w_abort) begin
            w_state_nxt = IDLE;
        end
    end

    assign w_done_entry = (r_state == DRAIN) && (w_state_nxt == DONE);

    // The detector output lags its input bit by one cycle, so hits are
    // only credited inside the delayed window.
    always_comb begin
        w_hit_cnt_nxt = r_hit_cnt;
        if (r_state == CLEAR) begin
            w_hit_cnt_nxt = '0;
        end else if (r_win && det_hit) begin
            w_hit_cnt_nxt = r_hit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_win       <= 1'b0;
            r_det_clear <= 1'b0;
            r_drain_cnt <= '0;
            r_hit_cnt   <= '0;
            r_out_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_win       <= (r_state == SHIFT);
            r_det_clear <= w_accept || w_abort;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + DRN_W'(1) : '0;
            r_hit_cnt   <= w_hit_cnt_nxt;
            if (w_done_entry) begin
                r_out_count <= w_hit_cnt_nxt;
            end
        end
    end

`ifdef FIRST_HIT_POS_EN
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] r_first_pos;
    logic [CNT_W-1:0] w_first_pos_nxt;
    logic [CNT_W-1:0] r_out_first_pos;

    // r_pos is the index of the bit that was driven in the previous cycle.
    always_comb begin
        w_first_pos_nxt = r_first_pos;
        if (r_state == CLEAR) begin
            w_first_pos_nxt = CNT_W'(WORD_W);
        end else if (r_win && det_hit && (r_first_pos == CNT_W'(WORD_W))) begin
            w_first_pos_nxt = r_pos;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos           <= '0;
            r_first_pos     <= '0;
            r_out_first_pos <= '0;
        end else begin
            if (r_state == CLEAR) begin
                r_pos <= '0;
            end else if (r_win) begin
                r_pos <= r_pos + CNT_W'(1);
            end
            r_first_pos <= w_first_pos_nxt;
            if (w_done_entry) begin
                r_out_first_pos <= w_first_pos_nxt;
            end
        end
    end

    assign out_first_pos = r_out_first_pos;
`endif

    assign in_ready      = (r_state == IDLE);
    assign det_clear     = r_det_clear;
    assign det_bit_valid = (r_state == SHIFT);
    assign det_data      = (r_state == SHIFT) && w_ser_q;
    assign out_valid     = (r_state == DONE);
    assign out_count     = r_out_count;

endmodule

`default_nettype wire

// File: tb/tb_pattern_scan_controller.sv
// +----------------------------------------------------------------------+
// | tb_pattern_scan_controller : scoreboard bench with a "1010" detector |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pattern_scan_controller;

    localparam int WORD_W    = 16;
    localparam int CNT_W     = 5;
    localparam int DRAIN_CYC = 1;
    localparam int LAT       = WORD_W + 2 + DRAIN_CYC;
    localparam int PERIOD    = WORD_W + 3 + DRAIN_CYC;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_word = '0;
    logic              abort = 1'b0;
    logic              det_clear;
    logic              det_bit_valid;
    logic              det_data;
    logic              det_hit;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CNT_W-1:0]  out_count;
`ifdef FIRST_HIT_POS_EN
    logic [CNT_W-1:0]  out_first_pos;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] pos;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [3:0] det_hist;

    pattern_scan_controller #(
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_word       (in_word),
        .abort         (abort),
        .det_clear     (det_clear),
        .det_bit_valid (det_bit_valid),
        .det_data      (det_data),
        .det_hit       (det_hit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef FIRST_HIT_POS_EN
        .out_first_pos (out_first_pos),
`endif
        .out_count     (out_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Overlapping "1010" Moore detector, registered output.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_hist <= 4'b0;
            det_hit  <= 1'b0;
        end else if (det_clear) begin
            det_hist <= 4'b0;
            det_hit  <= 1'b0;
        end else if (det_bit_valid) begin
            det_hist <= {det_hist[2:0], det_data};
            det_hit  <= ({det_hist[2:0], det_data} == 4'b1010);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Result monitor: pops the scoreboard on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("out_count", int'(out_count), int'(e.cnt));
`ifdef FIRST_HIT_POS_EN
                    check("out_first_pos", int'(out_first_pos), int'(e.pos));
`endif
                end
            end
        end
    end

    // Offer a word and wait (bounded) for acceptance; in_valid stays high.
    task automatic offer(input logic [WORD_W-1:0] w, input bit push,
                         input int cnt, input int pos, output int acc);
        bit got = 1'b0;
        acc = -1;
        in_word  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                acc = cyc;
                if (push) exp_q.push_back('{cnt: CNT_W'(cnt), pos: CNT_W'(pos)});
            end
        end
        if (!got) timeout("accept");
    endtask

    // Scan one word; checks stream bits and latency, returns at the negedge
    // where out_valid is first seen.
    task automatic run_word(input logic [WORD_W-1:0] w, input int cnt, input int pos);
        int acc;
        int nbits = 0;
        bit seen  = 1'b0;
        offer(w, 1'b1, cnt, pos, acc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (det_bit_valid) begin
                check("det_data", int'(det_data), int'((w >> nbits) & 1));
                nbits++;
            end
            if (out_valid) begin
                seen = 1'b1;
                check("latency", cyc - acc, LAT);
            end
        end
        check("bit_count", nbits, WORD_W);
        if (!seen) timeout("out_valid");
    endtask

    initial begin
        int  acc1;
        int  acc2;
        bit  flag;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_det_bit_valid", int'(det_bit_valid), 0);
        check("rst_det_clear", int'(det_clear), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a scan
        offer(16'h5555, 1'b0, 0, 0, acc1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midshift_bit_valid", int'(det_bit_valid), 1);
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_det_bit_valid", int'(det_bit_valid), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed words
        run_word(16'h5555, 7, 3);
        @(posedge clk); #1;
        run_word(16'h0000, 0, 16);
        @(posedge clk); #1;
        run_word(16'h000A, 1, 4);
        @(posedge clk); #1;
        run_word(16'hAAAA, 6, 4);
        @(posedge clk); #1;
        run_word(16'hFFFF, 0, 16);
        @(posedge clk); #1;

        // Result stall with a word offered meanwhile
        out_ready = 1'b0;
        run_word(16'h5555, 7, 3);
        @(posedge clk); #1;
        in_word  = 16'hFFFF;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_out_count", int'(out_count), 7);
            check("stall_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);

        // Abort in the 8th SHIFT cycle
        offer(16'h5555, 1'b0, 0, 0, acc1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("clear_pulse", int'(det_clear), 1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_in_shift", int'(det_bit_valid), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_det_clear", int'(det_clear), 1);
        check("abort_bit_valid", int'(det_bit_valid), 0);
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) flag = 1'b1;
        end
        check("abort_no_out_valid", int'(flag), 0);
        @(posedge clk); #1;
        run_word(16'h5555, 7, 3);
        @(posedge clk); #1;

        // Back-to-back words with in_valid held high
        offer(16'h000A, 1'b1, 1, 4, acc1);
        @(posedge clk); #1;
        offer(16'h5555, 1'b1, 7, 3, acc2);
        check("b2b_period", acc2 - acc1, PERIOD);
        @(posedge clk); #1;
        in_valid = 1'b0;

        for (int i = 0; i < 80 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) timeout("drain_scoreboard");
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
